mem_stage_dbus: RTL

- Memory-access stage of the 5-stage MIPS pipeline, between the EX/MEM latch and the MEM/WB latch.
- Converts the latched load/store controls into a req/ack transaction on an external data bus, and stalls the pipeline while the bus is busy.
- Byte-lane aligns and sign/zero-extends load data, then presents it as MEM_mem_data_out to the MEM/WB latch.
- Flags misaligned accesses and bus timeouts.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_stage_dbus_if.sv | 20 ++
 rtl/mem_load_align.sv | 23 ++
 rtl/mem_stage_dbus.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the MEM-stage data-bus bridge.
package mem_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } mem_state_e;

  // Store byte enables; size 2'b11 behaves as a word.
  function automatic logic [3:0] mem_byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      MEM_SIZE_BYTE: return 4'b0001 << lane;
      MEM_SIZE_HALF: return 4'b0011 << lane;
      default:       return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] mem_store_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      MEM_SIZE_BYTE: return {4{d[7:0]}};
      MEM_SIZE_HALF: return {2{d[15:0]}};
      default:       return d;
    endcase
  endfunction

  function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return ((size == MEM_SIZE_HALF) && lane[0]) || (size[1] && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_dbus_if.sv
// External data bus: registered request side from the MEM stage, ack/rdata from memory.
interface mem_stage_dbus_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    input  dbus_rdata, dbus_ack
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    output dbus_rdata, dbus_ack
  );
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed lane(s) of a read word and sign/zero-extends to 32 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (size)
      MEM_SIZE_BYTE: data = {{24{~uns & shifted[7]}}, shifted[7:0]};
      MEM_SIZE_HALF: data = {{16{~uns & shifted[15]}}, shifted[15:0]};
      default:       data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_dbus.sv
// MEM stage: turns latched load/store controls into a req/ack bus access and stalls
// the pipeline until it completes or times out.
module mem_stage_dbus
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_en,
  input  logic                MEM_MemRead,
  input  logic                MEM_MemWrite,
  input  logic [1:0]          MEM_mem_size,
  input  logic                MEM_mem_unsigned,
  input  logic [31:0]         MEM_ALU_result,
  input  logic [31:0]         MEM_mem_write_data,
  output logic [31:0]         MEM_mem_data_out,
  output logic                mem_stall,
  output logic                mem_misalign,
  output logic                mem_bus_error,
  mem_stage_dbus_if.master    dbus
);

  mem_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       data_q;
  logic              bus_err_q;
  logic              req_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              uns_q;

  logic              op;
  logic              misalign;
  logic [31:0]       load_data;

  assign op       = MEM_MemRead | MEM_MemWrite;
  assign misalign = op & mem_misaligned(MEM_mem_size, MEM_ALU_result[1:0]);

  // Access shape is latched at issue so capture does not depend on the held pipeline inputs.
  mem_load_align u_load_align (
    .rdata   (dbus.dbus_rdata),
    .addr_lo (lane_q),
    .size    (size_q),
    .uns     (uns_q),
    .data    (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      data_q    <= '0;
      bus_err_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (op && !misalign) begin
            req_q   <= 1'b1;
            // Read wins when both controls are high.
            we_q    <= MEM_MemWrite & ~MEM_MemRead;
            addr_q  <= {MEM_ALU_result[31:2], 2'b00};
            wdata_q <= mem_store_data(MEM_mem_size, MEM_mem_write_data);
            be_q    <= MEM_MemRead ? 4'b1111 : mem_byte_en(MEM_mem_size, MEM_ALU_result[1:0]);
            lane_q  <= MEM_ALU_result[1:0];
            size_q  <= MEM_mem_size;
            uns_q   <= MEM_mem_unsigned;
            cnt_q   <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + 1'b1;
          if (dbus.dbus_ack) begin
            data_q    <= we_q ? 32'h0 : load_data;
            req_q     <= 1'b0;
            bus_err_q <= 1'b0;
            state_q   <= StDone;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            data_q    <= '0;
            req_q     <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (cpu_en) begin
            bus_err_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_stall        = 1'b0;
    mem_misalign     = 1'b0;
    MEM_mem_data_out = '0;
    unique case (state_q)
      StIdle: begin
        mem_stall    = op & ~misalign;
        mem_misalign = misalign;
      end
      StWait: mem_stall = 1'b1;
      StDone: MEM_mem_data_out = data_q;
      default: ;
    endcase
  end

  assign mem_bus_error   = bus_err_q;
  assign dbus.dbus_req   = req_q;
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_wdata = wdata_q;
  assign dbus.dbus_be    = be_q;

endmodule
